burst_grant_lock: RTL and testbench
===================================

Name: burst_grant_lock

Overview:
- Downstream consumer of the combinational fixed-priority arbiter; port 0 has the highest priority.
- Presents per-port valid as `arb_req` to the arbiter and samples the returned one-hot `arb_gnt`.
- Locks the granted port as owner until its burst completes, then muxes that port's valid/data/last stream onto one valid/ready output.
- Enforces a maximum burst length so a single port cannot starve the others.

Parameters:
- PORTS, 4, number of requesters; must match the arbiter's `PORTS`.
- DATA_W, 32, width of each data beat.
- MAX_BEATS, 16, maximum beats per ownership; legal range is 1 to 256.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  PORTS  per-port beat valid.
- in_data  in  PORTS*DATA_W  per-port data; port i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  PORTS  per-port end-of-burst marker.
- in_ready  out  PORTS  per-port beat accept.
- arb_req  out  PORTS  request vector driven to the priority arbiter.
- arb_gnt  in  PORTS  one-hot grant returned by the arbiter, combinational from `arb_req`.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output beat data.
- out_last  out  1  output end-of-burst marker.
- out_port  out  $clog2(PORTS)  index of the current owner.
- out_ready  in  1  downstream accept.
- busy  out  1  high while a port owns the output.
- err  out  1  sticky flag: non-one-hot grant seen.

Behaviour:
- State elements:
  - State machine with states IDLE and OWN.
  - `owner_q`: PORTS bits, one-hot.
  - `beat_cnt`: $clog2(MAX_BEATS+1) bits.
  - `err_q`.
- Reset values (while `rst` is high, and on the first cycle after it falls):
  - state = IDLE, `owner_q` = 0, `beat_cnt` = 0, `err_q` = 0.
  - Outputs: `in_ready` = 0, `arb_req` = 0, `out_valid` = 0, `out_last` = 0, `out_port` = 0, `out_data` = 0, `busy` = 0, `err` = 0.
- IDLE:
  - `arb_req` = `in_valid`.
  - All `in_ready` = 0 and `out_valid` = 0; no beat is transferred in IDLE.
  - `arb_gnt` exactly one-hot: `owner_q` <= `arb_gnt`, `beat_cnt` <= 0, go to OWN.
  - `arb_gnt` == 0: stay in IDLE.
  - `arb_gnt` with more than one bit set: stay in IDLE and set `err_q` <= 1. `err_q` clears only on reset.
- OWN:
  - `arb_req` = 0, so no new grants are taken.
  - `busy` = 1 and `out_port` = encode(`owner_q`).
  - `out_valid` = `in_valid[owner]`; `out_data` = `in_data[owner]`.
  - `in_ready[owner]` = `out_ready`; all other `in_ready` bits = 0.
  - `out_last` = `in_last[owner]` OR (`beat_cnt` == MAX_BEATS-1).
  - Accepted beat = `out_valid` & `out_ready`. On each accepted beat, `beat_cnt` increments.
  - Accepted beat with `out_last` = 1: go to IDLE, `owner_q` <= 0, `beat_cnt` <= 0.
    - This covers forced release at MAX_BEATS even when `in_last` is 0; that port's remaining beats re-arbitrate as a new burst.
- Latency:
  - Data path is combinational in OWN; a beat transfers in the same cycle `out_ready` is high.
  - Grant takes 1 cycle: IDLE cycle, then the first beat can move in the next cycle.
  - Release costs exactly one IDLE bubble cycle between bursts.
- Handshake rules:
  - `out_valid`, once high, stays high and `out_data` is stable until accepted, provided the upstream port obeys the same rule.
  - `out_valid` never depends on `out_ready`.
  - An owner dropping `in_valid` mid-burst is legal: `out_valid` goes low and ownership is held.
- Simultaneous events:
  - A single beat with both `in_last` = 1 and `beat_cnt` == MAX_BEATS-1 causes a single release.
  - MAX_BEATS = 1 releases after every beat.
- Reset mid-burst: the owner is dropped immediately, with no partial-beat handling.

Decomposition:
- Package `arb_pkg`:
  - `state_t` enum {IDLE, OWN}.
  - Function `onehot_enc(PORTS)`.
  - Function `is_onehot`.
  - Localparam helpers for `$clog2` widths.
- No sub-module; the arbiter stays a sibling instance wired by the parent.
- The bench instantiates `priority_arbiter` plus `burst_grant_lock` together.

Test Plan:
- Reset: hold `rst` 3 cycles with all `in_valid` = 4'b1111 -> all outputs 0 during and on the first cycle after reset.
- Priority: `in_valid` = 4'b1010, port 1 sends 3 beats (0xA1, 0xA2, 0xA3; last on 0xA3), `out_ready` = 1 -> IDLE cycle, `out_port` = 1, beats appear in 3 consecutive cycles, 1 bubble, then port 3 is granted.
- Backpressure: during a port-0 burst, `out_ready` is held low 4 cycles -> `out_valid` = 1, `out_data` stable, `in_ready[0]` = 0; the beat is accepted on the first `out_ready` = 1 cycle.
- Forced release: MAX_BEATS = 4, port 2 streams 6 beats with `in_last` on beat 6 -> `out_last` = 1 on beat 4, bubble, then port 2 is regranted and beats 5–6 pass with `out_last` on beat 6.
- Hold under gap: owner port 0 drops `in_valid` for 2 cycles mid-burst while port 1 requests -> `busy` stays 1, `out_port` = 0, port 1 is not granted until port 0's last beat.
- Error and reset mid-burst: force `arb_gnt` = 4'b0011 in IDLE -> `err` = 1 and state stays IDLE. Assert `rst` in OWN -> next cycle `busy` = 0, `err` = 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst-locking grant stage.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Widest request vector the helpers below accept.
  localparam int MAX_PORTS = 32;

  // Width of a counter that must hold 0..max_beats.
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // Width of a port index; never narrower than one bit.
  function automatic int idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // Binary index of a one-hot vector (OR of set-bit indices).
  function automatic int onehot_enc(input logic [MAX_PORTS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_PORTS-1:0] v);
    return (v != '0) && ((v & (v - MAX_PORTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/priority_arbiter.sv
// Combinational fixed-priority arbiter; lowest index wins.
module priority_arbiter #(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] gnt
);

  // Isolate the lowest set request bit.
  assign gnt = req & (~req + PORTS'(1));

endmodule

// File: rtl/burst_grant_lock.sv
// Locks an arbiter grant for a whole burst and muxes the owner's
// valid/data/last stream onto a single output, capping burst length.
//
// state | meaning
// IDLE  | no owner; requests go to the arbiter, grant captured here
// OWN   | owner_q streams to the output until a last beat is accepted
module burst_grant_lock
  import arb_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS-1:0]        in_valid,
  input  logic [PORTS*DATA_W-1:0] in_data,
  input  logic [PORTS-1:0]        in_last,
  output logic [PORTS-1:0]        in_ready,
  output logic [PORTS-1:0]        arb_req,
  input  logic [PORTS-1:0]        arb_gnt,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [idx_w(PORTS)-1:0] out_port,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = idx_w(PORTS);
  localparam int CW = cnt_w(MAX_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  state_t            state_q, state_d;
  logic [PORTS-1:0]  owner_q, owner_d;
  logic [CW-1:0]     beat_cnt, beat_d;
  logic              err_q, err_d;
  // Holds requests off for the first cycle after reset is released.
  logic              rst_q;

  logic              own_valid, own_last;
  logic [DATA_W-1:0] own_data;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_cnt <= beat_d;
      err_q    <= err_d;
      rst_q    <= 1'b0;
    end
  end

  // Select the owner's upstream stream; owner_q is one-hot or zero.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (owner_q[i]) begin
        own_valid = in_valid[i];
        own_last  = in_last[i];
        own_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output decode; everything forced low while in reset.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    beat_d    = beat_cnt;
    err_d     = err_q;
    in_ready  = '0;
    arb_req   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_port  = '0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst_q) begin
          arb_req = in_valid;
          if (is_onehot(MAX_PORTS'(arb_gnt))) begin
            owner_d = arb_gnt;
            beat_d  = '0;
            state_d = OWN;
          end else if (arb_gnt != '0) begin
            err_d = 1'b1;
          end
        end
      end
      OWN: begin
        busy      = 1'b1;
        out_port  = PW'(onehot_enc(MAX_PORTS'(owner_q)));
        out_valid = own_valid;
        out_data  = own_data;
        in_ready  = owner_q & {PORTS{out_ready}};
        // Forced release at the beat cap merges with a real last beat.
        out_last  = own_last | (beat_cnt == LAST_CNT);
        if (own_valid && out_ready) begin
          beat_d = beat_cnt + CW'(1);
          if (out_last) begin
            state_d = IDLE;
            owner_d = '0;
            beat_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      in_ready  = '0;
      arb_req   = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      out_port  = '0;
      busy      = 1'b0;
    end
  end

  assign err = err_q & ~rst;

endmodule

// File: tb/tb_burst_grant_lock.sv
// Bench for burst_grant_lock: two instances (cap 16 and cap 4), each paired
// with a priority_arbiter, sharing stimulus and checked against an
// ownership model every cycle.
module tb_burst_grant_lock;

  localparam int P = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [P-1:0]  in_valid;
  logic [P*DW-1:0] in_data;
  logic [P-1:0]  in_last;
  logic          out_ready;
  logic          force_en;
  logic [P-1:0]  force_val;

  logic [P-1:0]  in_ready_w [2];
  logic [P-1:0]  arb_req_w  [2];
  logic [P-1:0]  arb_raw_w  [2];
  logic [P-1:0]  arb_gnt_w  [2];
  logic          out_valid_w [2];
  logic [DW-1:0] out_data_w [2];
  logic          out_last_w [2];
  logic [1:0]    out_port_w [2];
  logic          busy_w [2];
  logic          err_w [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  priority_arbiter #(.PORTS(P)) u_arb0 (.req(arb_req_w[0]), .gnt(arb_raw_w[0]));
  priority_arbiter #(.PORTS(P)) u_arb1 (.req(arb_req_w[1]), .gnt(arb_raw_w[1]));
  assign arb_gnt_w[0] = force_en ? force_val : arb_raw_w[0];
  assign arb_gnt_w[1] = force_en ? force_val : arb_raw_w[1];

  burst_grant_lock #(.PORTS(P), .DATA_W(DW), .MAX_BEATS(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_w[0]), .arb_req(arb_req_w[0]), .arb_gnt(arb_gnt_w[0]),
    .out_valid(out_valid_w[0]), .out_data(out_data_w[0]), .out_last(out_last_w[0]),
    .out_port(out_port_w[0]), .out_ready(out_ready), .busy(busy_w[0]), .err(err_w[0]));

  burst_grant_lock #(.PORTS(P), .DATA_W(DW), .MAX_BEATS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_w[1]), .arb_req(arb_req_w[1]), .arb_gnt(arb_gnt_w[1]),
    .out_valid(out_valid_w[1]), .out_data(out_data_w[1]), .out_last(out_last_w[1]),
    .out_port(out_port_w[1]), .out_ready(out_ready), .busy(busy_w[1]), .err(err_w[1]));

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [P-1:0] first_bit(input logic [P-1:0] r);
    for (int i = 0; i < P; i++) if (r[i]) return P'(1) << i;
    return '0;
  endfunction

  // Model: who owns each instance, how many beats it has moved, sticky error,
  // and whether requests are still held off after reset.
  int   maxb    [2] = '{16, 4};
  int   m_owner [2] = '{-1, -1};
  int   m_cnt   [2] = '{0, 0};
  bit   m_err   [2] = '{1'b0, 1'b0};
  bit   m_blk   [2] = '{1'b0, 1'b0};

  logic [P-1:0]  e_req, e_rdy, e_gnt;
  logic          e_val, e_last, e_busy;
  logic [1:0]    e_port;
  logic [DW-1:0] e_data;
  int            ow;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_req = '0; e_rdy = '0; e_val = 0; e_last = 0; e_busy = 0; e_port = '0; e_data = '0;
      ow = m_owner[k];
      if (!rst) begin
        if (ow < 0) begin
          if (!m_blk[k]) e_req = in_valid;
        end else begin
          e_busy = 1;
          e_port = 2'(ow);
          e_val  = in_valid[ow];
          e_data = DW'(in_data >> (ow * DW));
          e_rdy[ow] = out_ready;
          e_last = in_last[ow] || (m_cnt[k] == maxb[k] - 1);
        end
      end
      check("arb_req",   k, 32'(arb_req_w[k]),   32'(e_req));
      check("in_ready",  k, 32'(in_ready_w[k]),  32'(e_rdy));
      check("out_valid", k, 32'(out_valid_w[k]), 32'(e_val));
      check("out_data",  k, out_data_w[k],       e_data);
      check("out_last",  k, 32'(out_last_w[k]),  32'(e_last));
      check("out_port",  k, 32'(out_port_w[k]),  32'(e_port));
      check("busy",      k, 32'(busy_w[k]),      32'(e_busy));
      check("err",       k, 32'(err_w[k]),       32'(rst ? 1'b0 : m_err[k]));

      if (rst) begin
        m_owner[k] = -1; m_cnt[k] = 0; m_err[k] = 0; m_blk[k] = 1;
      end else begin
        if (ow < 0) begin
          if (!m_blk[k]) begin
            e_gnt = force_en ? force_val : first_bit(e_req);
            if ($countones(e_gnt) == 1) begin
              for (int i = 0; i < P; i++) if (e_gnt[i]) m_owner[k] = i;
              m_cnt[k] = 0;
            end else if ($countones(e_gnt) > 1) begin
              m_err[k] = 1;
            end
          end
        end else if (e_val && out_ready) begin
          m_cnt[k]++;
          if (e_last) begin
            m_owner[k] = -1;
            m_cnt[k] = 0;
          end
        end
        m_blk[k] = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_data(input int port, input logic [DW-1:0] v);
    in_data[port*DW +: DW] = v;
  endtask

  initial begin
    rst = 1; in_valid = 4'b1111; in_data = '0; in_last = '0;
    out_ready = 1; force_en = 0; force_val = '0;

    // Reset with every port requesting.
    repeat (3) begin
      mid();
      check("rst_req",  0, 32'(arb_req_w[0]), 32'h0);
      check("rst_busy", 0, 32'(busy_w[0]), 32'h0);
      cyc();
    end
    rst = 0;
    mid();
    check("post_rst_req", 0, 32'(arb_req_w[0]), 32'h0);
    check("post_rst_vld", 0, 32'(out_valid_w[0]), 32'h0);
    cyc();
    in_valid = '0;
    mid(); cyc();

    // Priority: port 1 burst of 3, then port 3 after one bubble.
    in_valid = 4'b1010; set_data(1, 32'hA1); set_data(3, 32'h33); in_last = 4'b1000;
    mid(); check("prio_req", 0, 32'(arb_req_w[0]), 32'hA); cyc();
    mid(); check("prio_port", 0, 32'(out_port_w[0]), 32'd1);
    check("prio_d1", 0, out_data_w[0], 32'hA1); cyc();
    set_data(1, 32'hA2);
    mid(); check("prio_d2", 0, out_data_w[0], 32'hA2); cyc();
    set_data(1, 32'hA3); in_last[1] = 1;
    mid(); check("prio_d3", 0, out_data_w[0], 32'hA3);
    check("prio_last", 0, 32'(out_last_w[0]), 32'd1); cyc();
    in_valid = 4'b1000; in_last[1] = 0;
    mid(); check("prio_bubble", 0, 32'(busy_w[0]), 32'd0); cyc();
    mid(); check("prio_p3", 0, 32'(out_port_w[0]), 32'd3); cyc();
    in_valid = '0; in_last = '0;
    mid(); cyc();

    // Backpressure on a port-0 burst.
    in_valid = 4'b0001; set_data(0, 32'hB0); out_ready = 0;
    mid(); cyc();
    repeat (4) begin
      mid();
      check("bp_valid", 0, 32'(out_valid_w[0]), 32'd1);
      check("bp_data",  0, out_data_w[0], 32'hB0);
      check("bp_rdy",   0, 32'(in_ready_w[0]), 32'h0);
      cyc();
    end
    out_ready = 1;
    mid(); check("bp_accept", 0, 32'(in_ready_w[0]), 32'h1); cyc();
    set_data(0, 32'hB1); in_last[0] = 1;
    mid(); check("bp_last", 0, 32'(out_last_w[0]), 32'd1); cyc();
    in_valid = '0; in_last = '0;
    mid(); cyc();

    // Forced release on the cap-4 instance: 6 beats from port 2.
    in_valid = 4'b0100; set_data(2, 32'hC1);
    mid(); cyc();
    for (int b = 1; b <= 4; b++) begin
      set_data(2, 32'hC0 + 32'(b));
      mid();
      check("cap_data", 1, out_data_w[1], 32'hC0 + 32'(b));
      check("cap_last", 1, 32'(out_last_w[1]), (b == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    set_data(2, 32'hC5);
    mid(); check("cap_bubble", 1, 32'(busy_w[1]), 32'd0); cyc();
    mid(); check("cap_d5", 1, out_data_w[1], 32'hC5);
    check("cap_l5", 1, 32'(out_last_w[1]), 32'd0); cyc();
    set_data(2, 32'hC6); in_last[2] = 1;
    mid(); check("cap_l6", 1, 32'(out_last_w[1]), 32'd1); cyc();
    in_valid = '0; in_last = '0;
    mid(); cyc(); mid(); cyc();

    // Owner gap while port 1 waits.
    in_valid = 4'b0011; set_data(0, 32'hD1); set_data(1, 32'hE1); in_last = 4'b0010;
    mid(); cyc();
    mid(); check("gap_p0", 0, 32'(out_port_w[0]), 32'd0); cyc();
    in_valid = 4'b0010;
    repeat (2) begin
      mid();
      check("gap_busy", 0, 32'(busy_w[0]), 32'd1);
      check("gap_port", 0, 32'(out_port_w[0]), 32'd0);
      check("gap_req",  0, 32'(arb_req_w[0]), 32'h0);
      cyc();
    end
    in_valid = 4'b0011; set_data(0, 32'hD2); in_last = 4'b0011;
    mid(); check("gap_last", 0, 32'(out_last_w[0]), 32'd1); cyc();
    in_valid = 4'b0010;
    mid(); check("gap_req1", 0, 32'(arb_req_w[0]), 32'h2); cyc();
    mid(); check("gap_p1", 0, 32'(out_port_w[0]), 32'd1); cyc();
    in_valid = '0; in_last = '0;
    mid(); cyc();

    // Non-one-hot grant, then reset while owning.
    in_valid = 4'b0011; force_en = 1; force_val = 4'b0011;
    mid(); cyc();
    mid(); check("err_set", 0, 32'(err_w[0]), 32'd1);
    check("err_idle", 0, 32'(busy_w[0]), 32'd0); cyc();
    force_en = 0; in_valid = 4'b0001; set_data(0, 32'hE0); out_ready = 0;
    mid(); cyc();
    mid(); check("err_own", 0, 32'(busy_w[0]), 32'd1); cyc();
    rst = 1;
    mid(); cyc();
    rst = 0;
    mid(); check("rst_busy2", 0, 32'(busy_w[0]), 32'd0);
    check("rst_err2", 0, 32'(err_w[0]), 32'd0); cyc();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = P'($urandom);
      for (int i = 0; i < P; i++) begin
        in_last[i] = ($urandom_range(0, 3) == 0);
        set_data(i, $urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 99) == 0);
      force_val = P'($urandom);
      mid(); cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
